// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared widths and enumerations for the reload timer.
//   CNT_W        : counter / reload register width
//   PSC_W        : prescaler width (used only when RELOAD_TIMER_PRESCALE_EN
//                  is defined)
//   mode_e       : terminal behaviour (ONESHOT stops, CONTINUOUS reloads)
//   run_state_e  : run-control FSM states
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam int CNT_W = 16;
    localparam int PSC_W = 4;

    typedef enum logic {
        ONESHOT    = 1'b0,
        CONTINUOUS = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/reload_timer_cnt.sv
// ---------------------------------------------------------------------------
// reload_timer_cnt
// Loadable down-counter with synchronous load, decrement enable and a
// registered zero flag.
// Ports:
//   clk_sys   in   clock, rising edge
//   rst_b     in   synchronous active-low reset (cnt=0, zero=1)
//   load      in   load load_val (has priority over dec)
//   load_val  in   value to load
//   dec       in   decrement by one
//   cnt       out  current count
//   zero      out  registered (cnt == 0)
// ---------------------------------------------------------------------------
module reload_timer_cnt
    import timer_pkg::*;
(
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = load_val;
        end else if (dec) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Zero flag is computed from the next value so it is valid in the same
    // cycle the count reaches zero, without a compare on the output path.
    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else begin
            cnt  <= cnt_nxt;
            zero <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/reload_timer.sv
// ---------------------------------------------------------------------------
// reload_timer
// 16-bit reload timer with one-shot / continuous modes, terminal-count pulse
// and sticky active-low interrupt.
// Optional: define RELOAD_TIMER_PRESCALE_EN to divide TICK by 16 with a
// 4-bit prescaler (cleared on START and on reload).
// Ports:
//   CLK    in   clock, rising edge
//   RSTL   in   synchronous active-low reset
//   DIN    in   [7:0] reload register write data
//   WR_LO  in   write DIN to RLD[7:0]
//   WR_HI  in   write DIN to RLD[15:8]
//   START  in   load CNT from RLD and run
//   STOP   in   halt and hold CNT (beats START)
//   MODE   in   0 one-shot, 1 continuous (sampled at terminal event)
//   TICK   in   count-enable strobe
//   ACK    in   release IRQL
//   CNT    out  [15:0] current count
//   RUN    out  timer running
//   TC     out  terminal-count pulse, one cycle
//   IRQL   out  sticky interrupt, active-low
//
// state   | meaning
// ST_IDLE | halted, CNT held, TICK ignored
// ST_RUN  | counting on each enable
// ---------------------------------------------------------------------------
module reload_timer
    import timer_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTL,
    input  logic [7:0]       DIN,
    input  logic             WR_LO,
    input  logic             WR_HI,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic             TICK,
    input  logic             ACK,
    output logic [CNT_W-1:0] CNT,
    output logic             RUN,
    output logic             TC,
    output logic             IRQL
);

    run_state_e       state, state_nxt;
    logic [CNT_W-1:0] rld;
    logic             cnt_en;
    logic             start_go;
    logic             count_ev;
    logic             terminal;
    logic             reload;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             tc_q;
    logic             irq_l_q;

    always_ff @(posedge CLK) begin
        if (!RSTL) begin
            rld <= '0;
        end else begin
            if (WR_LO) rld[7:0]  <= DIN;
            if (WR_HI) rld[15:8] <= DIN;
        end
    end

    assign start_go = START && !STOP;
    // STOP and START both pre-empt counting; a START coinciding with a
    // terminal event therefore loads cleanly with no TC.
    assign count_ev = RUN && cnt_en && !STOP && !start_go;
    assign terminal = count_ev && cnt_zero;
    assign reload   = terminal && (mode_e'(MODE) == CONTINUOUS);
    assign cnt_load = start_go || reload;
    assign cnt_dec  = count_ev && !cnt_zero;

`ifdef RELOAD_TIMER_PRESCALE_EN
    logic [PSC_W-1:0] psc;

    assign cnt_en = TICK && (psc == '1);

    always_ff @(posedge CLK) begin
        if (!RSTL) begin
            psc <= '0;
        end else if (cnt_load) begin
            psc <= '0;
        end else if (RUN && TICK && !STOP) begin
            psc <= psc + PSC_W'(1);
        end
    end
`else
    assign cnt_en = TICK;
`endif

    reload_timer_cnt u_cnt (
        .clk_sys  (CLK),
        .rst_b    (RSTL),
        .load     (cnt_load),
        .load_val (rld),
        .dec      (cnt_dec),
        .cnt      (CNT),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (!RSTL) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_go) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (STOP) begin
                    state_nxt = ST_IDLE;
                end else if (terminal && !reload) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Interrupt set has priority over ACK.
    always_ff @(posedge CLK) begin
        if (!RSTL) begin
            tc_q    <= 1'b0;
            irq_l_q <= 1'b1;
        end else begin
            tc_q <= terminal;
            if (terminal) begin
                irq_l_q <= 1'b0;
            end else if (ACK) begin
                irq_l_q <= 1'b1;
            end
        end
    end

    assign RUN  = (state == ST_RUN);
    assign TC   = tc_q;
    assign IRQL = irq_l_q;

endmodule

// File: tb/tb_reload_timer.sv
module tb_reload_timer;

    logic        CLK;
    logic        RSTL;
    logic [7:0]  DIN;
    logic        WR_LO;
    logic        WR_HI;
    logic        START;
    logic        STOP;
    logic        MODE;
    logic        TICK;
    logic        ACK;
    logic [15:0] CNT;
    logic        RUN;
    logic        TC;
    logic        IRQL;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [15:0] m_cnt;
    logic [15:0] m_rld;
    logic        m_run;
    logic        m_tc;
    logic        m_irql;
    int          m_psc;

    reload_timer dut (
        .CLK   (CLK),
        .RSTL  (RSTL),
        .DIN   (DIN),
        .WR_LO (WR_LO),
        .WR_HI (WR_HI),
        .START (START),
        .STOP  (STOP),
        .MODE  (MODE),
        .TICK  (TICK),
        .ACK   (ACK),
        .CNT   (CNT),
        .RUN   (RUN),
        .TC    (TC),
        .IRQL  (IRQL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural timer: what each edge does to the visible state.
    function automatic void model_update();
        bit en;
        bit tc_n;
        if (!RSTL) begin
            m_cnt = 16'h0; m_rld = 16'h0; m_run = 1'b0;
            m_tc = 1'b0; m_irql = 1'b1; m_psc = 0;
            return;
        end
        tc_n = 1'b0;
`ifdef RELOAD_TIMER_PRESCALE_EN
        en = TICK && (m_psc == 15);
`else
        en = TICK;
`endif
        if (STOP) begin
            m_run = 1'b0;
        end else if (START) begin
            m_cnt = m_rld;
            m_run = 1'b1;
            m_psc = 0;
        end else if (m_run) begin
            if (TICK) m_psc = (m_psc + 1) % 16;
            if (en) begin
                if (m_cnt != 0) begin
                    m_cnt = m_cnt - 16'd1;
                end else begin
                    tc_n = 1'b1;
                    m_psc = 0;
                    if (MODE) m_cnt = m_rld;
                    else      m_run = 1'b0;
                end
            end
        end
        if (WR_LO) m_rld[7:0]  = DIN;
        if (WR_HI) m_rld[15:8] = DIN;
        m_tc = tc_n;
        if (tc_n)     m_irql = 1'b0;
        else if (ACK) m_irql = 1'b1;
    endfunction

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        RSTL = 1'b1; DIN = 8'h00; WR_LO = 1'b0; WR_HI = 1'b0;
        START = 1'b0; STOP = 1'b0; MODE = 1'b0; TICK = 1'b0; ACK = 1'b0;
    endtask

    task automatic write_rld(input logic [15:0] val);
        DIN = val[7:0];  WR_LO = 1'b1; step(); WR_LO = 1'b0;
        DIN = val[15:8]; WR_HI = 1'b1; step(); WR_HI = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RSTL = 1'b0; START = 1'b1; TICK = 1'b1; WR_LO = 1'b1; DIN = 8'hFF;
        step();
        n_checks++; if (CNT !== 16'h0) $display("FAIL reset_cnt got=%h exp=0000", CNT); else n_pass++;
        n_checks++; if (RUN !== 1'b0) $display("FAIL reset_run got=%b exp=0", RUN); else n_pass++;
        n_checks++; if (TC !== 1'b0) $display("FAIL reset_tc got=%b exp=0", TC); else n_pass++;
        n_checks++; if (IRQL !== 1'b1) $display("FAIL reset_irql got=%b exp=1", IRQL); else n_pass++;
        idle_inputs();
        TICK = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_checks++; if (RUN !== 1'b0 || CNT !== 16'h0) $display("FAIL idle_tick run=%b cnt=%h exp run=0 cnt=0000", RUN, CNT); else n_pass++;
        TICK = 1'b0;
    endtask

    task automatic test_write_both();
        DIN = 8'hA5; WR_LO = 1'b1; WR_HI = 1'b1; step();
        WR_LO = 1'b0; WR_HI = 1'b0;
        START = 1'b1; STOP = 1'b1; step();
        n_checks++; if (RUN !== 1'b0 || CNT !== 16'h0) $display("FAIL start_stop run=%b cnt=%h exp run=0 cnt=0000", RUN, CNT); else n_pass++;
        STOP = 1'b0; step(); START = 1'b0;
        n_checks++; if (CNT !== 16'hA5A5) $display("FAIL both_bytes got=%h exp=a5a5", CNT); else n_pass++;
        n_checks++; if (RUN !== 1'b1) $display("FAIL start_run got=%b exp=1", RUN); else n_pass++;
        STOP = 1'b1; TICK = 1'b1; step(); STOP = 1'b0;
        step();
        n_checks++; if (RUN !== 1'b0 || CNT !== 16'hA5A5) $display("FAIL stop_hold run=%b cnt=%h exp run=0 cnt=a5a5", RUN, CNT); else n_pass++;
        TICK = 1'b0;
    endtask

    task automatic test_continuous();
        logic [15:0] exp_cnt;
        write_rld(16'h0003);
        MODE = 1'b1; START = 1'b1; step(); START = 1'b0;
        n_checks++; if (CNT !== 16'd3) $display("FAIL cont_load got=%0d exp=3", CNT); else n_pass++;
        TICK = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_cnt = 16'(3 - (i % 4));
            n_checks++; if (CNT !== exp_cnt) $display("FAIL cont_cnt cyc=%0d got=%0d exp=%0d", i, CNT, exp_cnt); else n_pass++;
            n_checks++; if (TC !== (i % 4 == 0)) $display("FAIL cont_tc cyc=%0d got=%b exp=%b", i, TC, (i % 4 == 0)); else n_pass++;
        end
        n_checks++; if (IRQL !== 1'b0) $display("FAIL cont_irql got=%b exp=0", IRQL); else n_pass++;
        TICK = 1'b0; ACK = 1'b1; step(); ACK = 1'b0;
        n_checks++; if (IRQL !== 1'b1) $display("FAIL cont_ack got=%b exp=1", IRQL); else n_pass++;
        STOP = 1'b1; step(); STOP = 1'b0;
    endtask

    task automatic test_oneshot();
        write_rld(16'h0002);
        MODE = 1'b0; START = 1'b1; step(); START = 1'b0;
        TICK = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (TC !== (i == 3)) $display("FAIL os_tc cyc=%0d got=%b exp=%b", i, TC, (i == 3)); else n_pass++;
        end
        n_checks++; if (RUN !== 1'b0 || CNT !== 16'h0 || IRQL !== 1'b0)
            $display("FAIL os_end run=%b cnt=%h irql=%b exp run=0 cnt=0000 irql=0", RUN, CNT, IRQL); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (TC !== 1'b0 || CNT !== 16'h0) $display("FAIL os_after tc=%b cnt=%h exp tc=0 cnt=0000", TC, CNT); else n_pass++;
        end
        TICK = 1'b0;
    endtask

    task automatic test_irq_priority();
        ACK = 1'b1; step(); ACK = 1'b0;
        n_checks++; if (IRQL !== 1'b1) $display("FAIL irq_clear got=%b exp=1", IRQL); else n_pass++;
        write_rld(16'h0001);
        MODE = 1'b0; START = 1'b1; step(); START = 1'b0;
        TICK = 1'b1; step();
        ACK = 1'b1; step();
        n_checks++; if (TC !== 1'b1) $display("FAIL irq_tc got=%b exp=1", TC); else n_pass++;
        n_checks++; if (IRQL !== 1'b0) $display("FAIL irq_set_wins got=%b exp=0", IRQL); else n_pass++;
        TICK = 1'b0; step(); ACK = 1'b0;
        n_checks++; if (IRQL !== 1'b1) $display("FAIL irq_lone_ack got=%b exp=1", IRQL); else n_pass++;
    endtask

    task automatic test_reload_write();
        logic [15:0] exp_seq [6];
        exp_seq = '{16'd2, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1};
        write_rld(16'h0005);
        MODE = 1'b1; START = 1'b1; step(); START = 1'b0;
        TICK = 1'b1; step(); step();
        n_checks++; if (CNT !== 16'd3) $display("FAIL rw_pre got=%0d exp=3", CNT); else n_pass++;
        DIN = 8'h01; WR_LO = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            WR_LO = 1'b0;
            n_checks++; if (CNT !== exp_seq[i]) $display("FAIL rw_cnt idx=%0d got=%0d exp=%0d", i, CNT, exp_seq[i]); else n_pass++;
        end
        TICK = 1'b0; STOP = 1'b1; step(); STOP = 1'b0;
        ACK = 1'b1; step(); ACK = 1'b0;
    endtask

    task automatic test_midcount_reset();
        write_rld(16'h0020);
        MODE = 1'b0; START = 1'b1; step(); START = 1'b0;
        TICK = 1'b1;
        for (int i = 0; i < 16; i++) step();
        n_checks++; if (CNT !== 16'h0010) $display("FAIL mr_pre got=%h exp=0010", CNT); else n_pass++;
        RSTL = 1'b0; step(); RSTL = 1'b1;
        n_checks++; if (CNT !== 16'h0 || RUN !== 1'b0 || TC !== 1'b0 || IRQL !== 1'b1)
            $display("FAIL mr_reset cnt=%h run=%b tc=%b irql=%b exp 0000 0 0 1", CNT, RUN, TC, IRQL); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (RUN !== 1'b0 || TC !== 1'b0 || CNT !== 16'h0)
                $display("FAIL mr_idle run=%b tc=%b cnt=%h exp 0 0 0000", RUN, TC, CNT); else n_pass++;
        end
        TICK = 1'b0;
    endtask

    task automatic test_prescale();
        bit exp_tc;
        int tc_seen;
        tc_seen = 0;
        write_rld(16'h0000);
        MODE = 1'b1; START = 1'b1; step(); START = 1'b0;
        TICK = 1'b1;
        for (int i = 1; i <= 48; i++) begin
            step();
`ifdef RELOAD_TIMER_PRESCALE_EN
            exp_tc = (i % 16 == 0);
`else
            exp_tc = 1'b1;
`endif
            if (TC === 1'b1) tc_seen++;
            n_checks++; if (TC !== exp_tc) $display("FAIL psc_tc cyc=%0d got=%b exp=%b", i, TC, exp_tc); else n_pass++;
        end
`ifdef RELOAD_TIMER_PRESCALE_EN
        n_checks++; if (tc_seen != 3) $display("FAIL psc_count got=%0d exp=3", tc_seen); else n_pass++;
`else
        n_checks++; if (tc_seen != 48) $display("FAIL psc_count got=%0d exp=48", tc_seen); else n_pass++;
`endif
        TICK = 1'b0; STOP = 1'b1; ACK = 1'b1; step(); STOP = 1'b0; ACK = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            RSTL  = ($urandom_range(0, 127) != 0);
            START = ($urandom_range(0, 15) == 0);
            STOP  = ($urandom_range(0, 31) == 0);
            MODE  = 1'($urandom_range(0, 1));
            TICK  = ($urandom_range(0, 1) == 1);
            ACK   = ($urandom_range(0, 7) == 0);
            WR_LO = ($urandom_range(0, 7) == 0);
            WR_HI = ($urandom_range(0, 15) == 0);
            if (WR_HI) DIN = ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0;
            else       DIN = 8'($urandom_range(0, 6));
            step();
            n_checks++; if (CNT !== m_cnt) $display("FAIL rnd_cnt cyc=%0d got=%h exp=%h", i, CNT, m_cnt); else n_pass++;
            n_checks++; if (RUN !== m_run) $display("FAIL rnd_run cyc=%0d got=%b exp=%b", i, RUN, m_run); else n_pass++;
            n_checks++; if (TC !== m_tc) $display("FAIL rnd_tc cyc=%0d got=%b exp=%b", i, TC, m_tc); else n_pass++;
            n_checks++; if (IRQL !== m_irql) $display("FAIL rnd_irql cyc=%0d got=%b exp=%b", i, IRQL, m_irql); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_both();
`ifndef RELOAD_TIMER_PRESCALE_EN
        test_continuous();
        test_oneshot();
        test_irq_priority();
        test_reload_write();
        test_midcount_reset();
`endif
        test_prescale();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reload_timer.md
RELOAD_TIMER -- requirements
Module: reload_timer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port RSTL, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port DIN, input, 8 bits: reload-register write data.
REQ-004 SHALL have port WR_LO, input, 1 bit: write DIN to RLD[7:0].
REQ-005 SHALL have port WR_HI, input, 1 bit: write DIN to RLD[15:8].
REQ-006 SHALL have port START, input, 1 bit: load counter from RLD and run.
REQ-007 SHALL have port STOP, input, 1 bit: halt counting and hold the count.
REQ-008 SHALL have port MODE, input, 1 bit: 0 = one-shot, 1 = continuous.
REQ-009 SHALL have port TICK, input, 1 bit: count-enable strobe.
REQ-010 SHALL have port ACK, input, 1 bit: clear interrupt.
REQ-011 SHALL have port CNT, output, 16 bits: current count.
REQ-012 SHALL have port RUN, output, 1 bit: timer running.
REQ-013 SHALL have port TC, output, 1 bit: terminal-count pulse, one cycle wide.
REQ-014 SHALL have port IRQL, output, 1 bit: sticky interrupt, active-low.

Function
REQ-015 SHALL register every output; no combinational path from any input to any output.
REQ-016 SHALL update RLD bytes one cycle after WR_LO or WR_HI; when both are asserted together, DIN SHALL be written to both bytes.
REQ-017 SHALL set CNT to RLD and RUN to 1 on the edge where START=1.
REQ-018 SHALL restart from RLD when START is asserted while RUN=1.
REQ-019 SHALL clear RUN and hold CNT on STOP; when START and STOP are asserted in the same cycle, STOP SHALL win.
REQ-020 SHALL decrement CNT by 1 on each counting event (RUN=1 and count enable) while CNT is non-zero.
REQ-021 SHALL treat a counting event at CNT=0 as terminal: TC=1 for exactly the following cycle, and IRQL set to 0.
REQ-022 SHALL, on a terminal event in continuous mode, reload CNT from RLD, giving a period of RLD+1 enables; RLD=0 SHALL produce TC on every enable.
REQ-023 SHALL, on a terminal event in one-shot mode, clear RUN and hold CNT at 0.
REQ-024 SHALL sample MODE at the terminal event, not at START.
REQ-025 SHALL, when RLD is written while running, apply the new value only at the next START or reload; the current count is unaffected.
REQ-026 SHALL, when a START arrives in the same cycle as a terminal event, give START priority: load RLD with no TC and no IRQL change.
REQ-027 SHALL release IRQL to 1 the cycle after ACK=1; when ACK coincides with a terminal event, IRQL SHALL stay 0 (set wins).
REQ-028 SHALL ignore TICK while RUN=0.

Reset
REQ-029 SHALL, on the CLK edge with RSTL=0, set CNT=0x0000, RLD=0x0000, RUN=0, TC=0, IRQL=1 and the prescaler to 0, overriding all other inputs.
REQ-030 SHALL, when reset is applied mid-count, abandon the count with no TC; after release the timer stays idle until START.

Configuration
REQ-031 SHALL, when macro RELOAD_TIMER_PRESCALE_EN is defined, make the count enable a fixed 4-bit prescaler: one count enable per 16 TICK pulses while running, with the prescaler cleared on START and on reload.
REQ-032 SHALL, when RELOAD_TIMER_PRESCALE_EN is undefined, use count enable = TICK directly, with no prescaler logic present and the port list unchanged.

Structure
REQ-033 SHALL take CNT_W=16, PSC_W=4 and a mode enum (ONESHOT, CONTINUOUS) from the shared package timer_pkg.
REQ-034 SHALL instantiate one sub-module, reload_timer_cnt: a 16-bit loadable down-counter with synchronous load, enable and registered zero flag.

Verification
REQ-035 SHALL verify continuous period: RLD=0x0003, MODE=1, START, TICK every cycle -> TC on cycles 4, 8 and 12 after START; CNT sequence 3,2,1,0,3.
REQ-036 SHALL verify one-shot: RLD=0x0002, MODE=0, START, 3 TICKs -> one TC, RUN=0, CNT=0, IRQL=0; further TICKs produce no TC.
REQ-037 SHALL verify interrupt priority: ACK asserted in the same cycle as a terminal event -> IRQL remains 0; a lone ACK one cycle later -> IRQL=1.
REQ-038 SHALL verify reload write while running: RLD=0x0005 running, write RLD=0x0001 at CNT=3 -> 3,2,1,0, then reload to 1.
REQ-039 SHALL verify mid-count reset: RSTL=0 at CNT=0x0010 -> all outputs at reset values the next cycle, no TC; TICKs ignored until START.
REQ-040 SHALL verify the prescaler, with RELOAD_TIMER_PRESCALE_EN defined: RLD=0, MODE=1 -> TC once per 16 TICKs; with the macro undefined -> TC on every TICK.
